// File: rtl/t_ramp_gen_pkg.sv
// Shared fixed-point and state definitions for the temperature path.
// T samples are signed Q7.0; the ramp accumulator is signed Q8.7.
package t_ramp_gen_pkg;

  localparam int FRAC_BITS = 7;
  localparam int T_W       = 8;
  localparam int ACC_W     = T_W + FRAC_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Q7.0 -> Q8.7, sign-extended into the accumulator width
  function automatic logic signed [ACC_W-1:0] t_to_acc(input logic signed [T_W-1:0] t);
    return {t[T_W-1], t, {FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/t_ramp_gen_sample_tick_div.sv
// Sample-rate divider: counts 0..TICK_DIV-1 while enabled, tick on the last count.
// clear restarts the count at 0 so the first tick lands TICK_DIV clocks later.
module sample_tick_div #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/t_ramp_gen.sv
// Temperature trajectory source: start value, clamped ramp to target, hold, done.
// One registered sample per TICK_DIV clocks; abort returns to IDLE, keeping T_out.
module t_ramp_gen
  import t_ramp_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic signed [T_W-1:0] T_start,
  input  logic signed [T_W-1:0] T_target,
  input  logic        [T_W-1:0] rate,
  input  logic        [T_W-1:0] hold_len,
  output logic signed [T_W-1:0] T_out,
  output logic                  t_valid,
  output logic                  init_out,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [T_W-1:0]   tgt_q, tgt_d;
  logic        [T_W-1:0]   rate_q, rate_d;
  logic        [T_W-1:0]   hold_len_q, hold_len_d;
  logic        [T_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                    dir_up_q, dir_up_d;
  logic signed [T_W-1:0]   t_out_q, t_out_d;
  logic                    t_valid_q, t_valid_d;
  logic                    init_q, init_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    start_acc;
  logic                    tick;
  logic signed [ACC_W:0]   acc_ext, rate_ext, tgt_ext, step_sum;
  logic                    reached;

  assign start_acc = start && !abort && (state_q == ST_IDLE);

  sample_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_acc || abort),
    .en    (state_q != ST_IDLE),
    .tick  (tick)
  );

  // One extra bit so a step past +/-full scale is compared, not wrapped
  assign acc_ext  = {acc_q[ACC_W-1], acc_q};
  assign rate_ext = $signed({{(ACC_W + 1 - T_W){1'b0}}, rate_q});
  assign tgt_ext  = {tgt_q[T_W-1], t_to_acc(tgt_q)};
  assign step_sum = dir_up_q ? (acc_ext + rate_ext) : (acc_ext - rate_ext);
  assign reached  = dir_up_q ? (step_sum >= tgt_ext) : (step_sum <= tgt_ext);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tgt_d      = tgt_q;
    rate_d     = rate_q;
    hold_len_d = hold_len_q;
    hold_cnt_d = hold_cnt_q;
    dir_up_d   = dir_up_q;
    t_out_d    = t_out_q;
    t_valid_d  = 1'b0;
    init_d     = 1'b0;
    done_d     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tgt_d      = T_target;
            rate_d     = rate;
            hold_len_d = hold_len;
            hold_cnt_d = hold_len;
            dir_up_d   = (T_target > T_start);
            acc_d      = t_to_acc(T_start);
            t_out_d    = T_start;
            t_valid_d  = 1'b1;
            init_d     = 1'b1;
            // Zero rate holds at the start value, never jumping to target
            state_d    = ((rate == '0) || (T_start == T_target)) ? ST_HOLD : ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (tick) begin
            if (reached) begin
              acc_d      = t_to_acc(tgt_q);
              hold_cnt_d = hold_len_q;
              state_d    = ST_HOLD;
            end else begin
              acc_d = step_sum[ACC_W-1:0];
            end
            t_out_d   = acc_d[FRAC_BITS +: T_W];
            t_valid_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hold_cnt_q == '0) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              t_out_d    = acc_q[FRAC_BITS +: T_W];
              t_valid_d  = 1'b1;
              hold_cnt_d = hold_cnt_q - 8'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      tgt_q      <= '0;
      rate_q     <= '0;
      hold_len_q <= '0;
      hold_cnt_q <= '0;
      dir_up_q   <= 1'b0;
      t_out_q    <= '0;
      t_valid_q  <= 1'b0;
      init_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tgt_q      <= tgt_d;
      rate_q     <= rate_d;
      hold_len_q <= hold_len_d;
      hold_cnt_q <= hold_cnt_d;
      dir_up_q   <= dir_up_d;
      t_out_q    <= t_out_d;
      t_valid_q  <= t_valid_d;
      init_q     <= init_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign T_out    = t_out_q;
  assign t_valid  = t_valid_q;
  assign init_out = init_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_t_ramp_gen.sv
// Directed bench for t_ramp_gen with TICK_DIV=4: sample values, spacing, strobes,
// abort/start interaction and asynchronous reset mid-run.
module tb_t_ramp_gen;

  localparam int TDIV = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic signed [7:0] T_start;
  logic signed [7:0] T_target;
  logic        [7:0] rate;
  logic        [7:0] hold_len;
  logic signed [7:0] T_out;
  logic              t_valid;
  logic              init_out;
  logic              busy;
  logic              done;

  t_ramp_gen #(.TICK_DIV(TDIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .T_start  (T_start),
    .T_target (T_target),
    .rate     (rate),
    .hold_len (hold_len),
    .T_out    (T_out),
    .t_valid  (t_valid),
    .init_out (init_out),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;

  int samp_q[$];
  int samp_cyc[$];
  int exp_q[$];
  int init_cnt, init_cyc, done_cyc, busy_bad, busy_done, busy_after;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input int ts, input int tt, input int r, input int h);
    @(negedge clk);
    T_start  = ts[7:0];
    T_target = tt[7:0];
    rate     = r[7:0];
    hold_len = h[7:0];
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Records one run from its first sample through done; inj>=0 pulses a stray start
  task automatic run(input int ts, input int tt, input int r, input int h,
                     input int inj, input int max_cyc);
    samp_q.delete();
    samp_cyc.delete();
    init_cnt = 0; init_cyc = -1; done_cyc = -1; busy_bad = 0; busy_done = 1;
    launch(ts, tt, r, h);
    for (int c = 0; c < max_cyc && done_cyc < 0; c++) begin
      if (t_valid) begin
        samp_q.push_back(int'(T_out));
        samp_cyc.push_back(c);
      end
      if (init_out) begin
        init_cnt++;
        init_cyc = c;
      end
      if (done) begin
        done_cyc  = c;
        busy_done = int'(busy);
      end else if (!busy) begin
        busy_bad++;
      end
      if (c == inj) begin
        start = 1'b1; T_start = 8'sd99; T_target = -8'sd50; rate = 8'd7; hold_len = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    busy_after = int'(busy);
    if (done_cyc < 0) check("run_timeout", 0, 1);
  endtask

  task automatic verify(input string tag, input int exp_done);
    check({tag, "_nsamp"}, samp_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < samp_q.size(); i++) begin
      check($sformatf("%s_val%0d", tag, i), samp_q[i], exp_q[i]);
      check($sformatf("%s_cyc%0d", tag, i), samp_cyc[i], TDIV * i);
    end
    check({tag, "_init_cnt"}, init_cnt, 1);
    check({tag, "_init_cyc"}, init_cyc, 0);
    check({tag, "_done_cyc"}, done_cyc, exp_done);
    check({tag, "_busy_gap"}, busy_bad, 0);
    check({tag, "_busy_done"}, busy_done, 0);
    check({tag, "_busy_after"}, busy_after, 0);
  endtask

  int bad;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    T_start = '0; T_target = '0; rate = '0; hold_len = '0;
    repeat (3) @(negedge clk);
    check("rst_T_out", int'(T_out), 0);
    check("rst_t_valid", int'(t_valid), 0);
    check("rst_init", int'(init_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(20, 23, 128, 2, -1, 60);
    exp_q = '{20, 21, 22, 23, 23, 23};
    verify("up1", 24);

    run(0, 1, 64, 0, -1, 60);
    exp_q = '{0, 0, 1};
    verify("frac", 12);

    run(10, 8, 96, 1, -1, 60);
    exp_q = '{10, 9, 8, 8, 8};
    verify("down", 20);

    run(-128, 127, 255, 0, -1, 700);
    exp_q.delete();
    for (int k = 0; k <= 128; k++) exp_q.push_back((-16384 + 255 * k) >>> 7);
    verify("full", 129 * TDIV);

    run(5, 5, 100, 1, -1, 60);
    exp_q = '{5, 5};
    verify("equal", 8);

    run(3, 9, 0, 1, -1, 60);
    exp_q = '{3, 3};
    verify("rate0", 8);

    // Abort on the third sample with a simultaneous start
    launch(20, 40, 128, 0);
    check("ab_first_valid", int'(t_valid), 1);
    repeat (2 * TDIV) @(negedge clk);
    check("ab_third_valid", int'(t_valid), 1);
    check("ab_third_val", int'(T_out), 22);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("ab_busy", int'(busy), 0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (t_valid || done || busy || init_out) bad++;
      @(negedge clk);
    end
    check("ab_quiet", bad, 0);
    check("ab_T_hold", int'(T_out), 22);

    // Start while busy is ignored; the clean run after the abort inits again
    run(20, 23, 128, 2, 6, 60);
    exp_q = '{20, 21, 22, 23, 23, 23};
    verify("busy_start", 24);

    // Start and abort together while idle
    T_start = 8'sd7; T_target = 8'sd9; rate = 8'd64; hold_len = 8'd0;
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (t_valid || busy || init_out || done) bad++;
      @(negedge clk);
    end
    check("idle_abort_start", bad, 0);

    // Asynchronous reset on a HOLD sample
    launch(20, 23, 128, 2);
    repeat (4 * TDIV) @(negedge clk);
    check("rr_hold_valid", int'(t_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rr_T_out", int'(T_out), 0);
    check("rr_t_valid", int'(t_valid), 0);
    check("rr_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (t_valid || busy || init_out || done) bad++;
      @(negedge clk);
    end
    check("rr_quiet", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_ramp_gen.md
# t_ramp_gen

Sample-stream source that produces a Q7.0 temperature trajectory (T_start, ramp at a programmed slope to T_target, hold, done) for the dT estimation path. Emits one T sample per sample tick with a valid strobe, plus a one-cycle init strobe on the first sample so the downstream estimator resets cleanly. Used as the on-chip stimulus and self-test generator in front of the controller's T input.

## Interface
- TICK_DIV, 16: clocks per output sample; legal range 2..65535.
- FRAC_BITS, 7: fractional bits of the internal accumulator (Q8.7). Fixed at 7.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  level or pulse; forces IDLE.
- T_start  in  8  signed Q7.0 initial temperature; latched on accepted start.
- T_target  in  8  signed Q7.0 final temperature; latched on accepted start.
- rate  in  8  unsigned Q1.7 step magnitude per sample (0..1.9921875); latched on start.
- hold_len  in  8  samples emitted at T_target after reaching it; latched on start.
- T_out  out  8  signed Q7.0 current sample.
- t_valid  out  1  one-cycle strobe: T_out is a new sample.
- init_out  out  1  one-cycle strobe coincident with the first t_valid of a run.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle strobe at normal completion.

## Operation
- States: IDLE, RAMP, HOLD.
- Accumulator acc: signed 16-bit Q8.7. T_out = acc[14:7] (arithmetic floor of acc/128).
- IDLE + start (abort low): latch inputs; acc <= T_start<<7; tick counter <= 0; emit first sample (T_out=T_start, t_valid=1, init_out=1) on the following cycle. Next state RAMP, or HOLD if rate==0 or T_start==T_target.
- rate==0 with T_start!=T_target: go to HOLD at T_start (no movement); hold value is acc, not T_target.
- Direction fixed at start: up if T_target>T_start, else down.
- RAMP, on each sample tick: acc_next = acc ± rate (17-bit intermediate). If acc_next reaches or passes T_target<<7, acc <= T_target<<7 and go HOLD with hold counter <= hold_len; else acc <= acc_next. Emit sample (t_valid=1).
- HOLD, on each sample tick: if hold counter==0, pulse done, go IDLE, no sample. Else emit sample at current acc, decrement.
- hold_len==0: done pulses on the tick after the sample that reached target.
- abort (any state, highest priority over start and tick): IDLE next cycle; no t_valid, no done; T_out keeps last value.
- start while busy: ignored. start and abort in same cycle: abort wins.
- Input changes while busy have no effect.

## Timing
- Reset values: T_out=0, t_valid=0, init_out=0, busy=0, done=0, acc=0, state IDLE.
- Latency: start accepted at edge N; first t_valid/init_out high in cycle N+1; busy high from N+1.
- Sample tick: counter counts 0..TICK_DIV-1 from the first sample; subsequent t_valid strobes exactly TICK_DIV clocks apart.
- done occurs TICK_DIV clocks after the last sample; busy drops in the same cycle as done is high → low next cycle; a new start is accepted from the cycle done is high's successor.
- All outputs registered; no combinational path input→output.
- Reset mid-run: all outputs return to reset values asynchronously; no residual strobes after release.

## Structure
- Shared package: FRAC_BITS, state encoding (IDLE/RAMP/HOLD), Q7.0↔Q8.7 conversion constants reused by estimator and controller.
- One sub-module: sample_tick_div (parameter TICK_DIV; inputs clk, rst_n, clear, en; output tick pulse). FSM, accumulator and clamp in top.

## Test plan
- TICK_DIV=4, T_start=20, T_target=23, rate=128, hold_len=2 → samples 20(init),21,22,23,23,23 spaced 4 clocks; done 4 clocks after last; busy low after.
- T_start=0, T_target=1, rate=64, hold_len=0 → acc 0,64,128 → samples 0(init),0,1; done next tick.
- T_start=10, T_target=8, rate=96, hold_len=1 → acc 1280,1184,1088,clamp 1024 → samples 10,9,8,8,8; no undershoot below 8.
- T_start=-128, T_target=127, rate=255 → monotonic ascent, no wrap, final 127 exactly; T_start=T_target=5 → first sample then HOLD directly.
- Abort during RAMP third sample; start in same cycle as abort; start while busy → immediate IDLE, no done, ignored starts, next clean start gives init_out again.
- rst_n asserted mid-HOLD, released → all outputs 0, busy 0, no strobes until next start.
